// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a length-prefixed big-endian byte stream into
// 16-bit instruction-memory writes and holds the CPU in reset until the load is done.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wl_q, wl_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        xfer;

  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    wl_d    = wl_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_HI;
          wl_d    = '0;
          addr_d  = BASE_ADDR;
        end
      end
      LEN_HI: begin
        if (abort) begin
          state_d = ERROR;
        end else if (xfer) begin
          count_d = {in_data, count_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (abort) begin
          state_d = ERROR;
        end else if (xfer) begin
          count_d = {count_q[15:8], in_data};
          if (count_d == 16'd0)
            state_d = DONE;
          else if ({1'b0, count_d} > MAX_W)
            state_d = ERROR;
          else
            state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (abort) begin
          state_d = ERROR;
        end else if (xfer) begin
          hi_d    = in_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (abort) begin
          state_d = ERROR;
        end else if (xfer) begin
          wdata_d = {hi_q, in_data};
          state_d = WRITE;
        end
      end
      WRITE: begin
        // The write in this cycle always lands, even if abort arrives with it.
        wl_d   = wl_q + 16'd1;
        addr_d = addr_q + 16'd2;
        if (abort)
          state_d = ERROR;
        else if (wl_d == count_q)
          state_d = DONE;
        else
          state_d = DATA_HI;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                 (state_d == DATA_HI) || (state_d == DATA_LO);
    mem_we_d   = (state_d == WRITE);
    busy_d     = in_ready_d || mem_we_d;
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
    cpu_hold_d = (state_d != DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      hi_q       <= '0;
      wdata_q    <= '0;
      addr_q     <= BASE_ADDR;
      wl_q       <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      hi_q       <= hi_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      wl_q       <= wl_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams in, observed memory writes and
// status levels compared against hand-computed values.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset, start, abort, in_valid;
  logic [7:0]  in_data;
  logic        in_ready, mem_we, cpu_hold, busy, done, error;
  logic [15:0] mem_addr, mem_wdata, words_loaded;

  int total = 0;
  int bad   = 0;
  logic [15:0] wa[$];
  logic [15:0] wd[$];

  imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write pulse is logged; the loader must never offer a byte in a write cycle.
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      chk("ready_in_write", {31'd0, in_ready}, 32'd0);
    end
  end

  // Entered and left on a negedge; the byte transfers on the edge where in_ready is seen high.
  task automatic push(input logic [7:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready === 1'b1) ok = 1;
      @(negedge clock);
    end
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_gap(input logic [7:0] b);
    int n;
    n = $urandom_range(0, 2);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    repeat (n) @(negedge clock);
    push(b);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Idle after reset: stream bytes must be ignored and the CPU held.
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (6) @(negedge clock);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'h0000);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'h0000);
    chk("rst_wl", {16'd0, words_loaded}, 32'd0);
    chk("rst_nowrite", wa.size(), 32'd0);
    in_valid = 1'b0;

    // Two-word load, in_valid held high throughout.
    clear_log();
    pulse_start();
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_ready", {31'd0, in_ready}, 32'd1);
    push(8'h00); push(8'h02); push(8'h12); push(8'h34); push(8'hAB); push(8'hCD);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("t2_nwr", wa.size(), 32'd2);
    if (wa.size() == 2) begin
      chk("t2_a0", {16'd0, wa[0]}, 32'h0000);
      chk("t2_d0", {16'd0, wd[0]}, 32'h1234);
      chk("t2_a1", {16'd0, wa[1]}, 32'h0002);
      chk("t2_d1", {16'd0, wd[1]}, 32'hABCD);
    end
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t2_busy_end", {31'd0, busy}, 32'd0);
    chk("t2_wl", {16'd0, words_loaded}, 32'd2);
    chk("t2_addr", {16'd0, mem_addr}, 32'h0004);

    // Zero count finishes immediately.
    clear_log();
    pulse_start();
    chk("t3_restart_done", {31'd0, done}, 32'd0);
    push(8'h00); push(8'h00);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_nwr", wa.size(), 32'd0);
    chk("t3_wl", {16'd0, words_loaded}, 32'd0);

    // Count 257 exceeds the limit.
    pulse_start();
    push(8'h01); push(8'h01);
    in_valid = 1'b0;
    @(negedge clock);
    chk("t4_error", {31'd0, error}, 32'd1);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_nwr", wa.size(), 32'd0);

    // Count 256 is exactly at the limit and accepted; abort in DATA_HI.
    pulse_start();
    chk("t4b_err_clr", {31'd0, error}, 32'd0);
    push(8'h01); push(8'h00);
    in_valid = 1'b0;
    chk("t4b_ready", {31'd0, in_ready}, 32'd1);
    chk("t4b_noerr", {31'd0, error}, 32'd0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t4b_error", {31'd0, error}, 32'd1);
    chk("t4b_wl", {16'd0, words_loaded}, 32'd0);

    // Count 3, one word, abort after the next high byte; a start pulse while busy is ignored.
    clear_log();
    pulse_start();
    push(8'h00);
    start = 1'b1;
    push(8'h03);
    start = 1'b0;
    push(8'h11); push(8'h22); push(8'h33);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t5_error", {31'd0, error}, 32'd1);
    chk("t5_wl", {16'd0, words_loaded}, 32'd1);
    chk("t5_nwr", wa.size(), 32'd1);
    if (wa.size() == 1) begin
      chk("t5_a0", {16'd0, wa[0]}, 32'h0000);
      chk("t5_d0", {16'd0, wd[0]}, 32'h1122);
    end

    // Abort coinciding with WRITE: the write still counts.
    clear_log();
    pulse_start();
    push(8'h00); push(8'h02); push(8'h55); push(8'h66);
    in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("t5b_error", {31'd0, error}, 32'd1);
    chk("t5b_wl", {16'd0, words_loaded}, 32'd1);
    chk("t5b_nwr", wa.size(), 32'd1);
    if (wd.size() == 1) chk("t5b_d0", {16'd0, wd[0]}, 32'h5566);
    chk("t5b_addr", {16'd0, mem_addr}, 32'h0002);

    // Three-word load with gappy in_valid, reset during the second WRITE.
    clear_log();
    pulse_start();
    push_gap(8'h00); push_gap(8'h03); push_gap(8'hA1); push_gap(8'hA2);
    push_gap(8'hB1); push_gap(8'hB2);
    chk("t6_we_before", {31'd0, mem_we}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_we", {31'd0, mem_we}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t6_rst_wl", {16'd0, words_loaded}, 32'd0);
    chk("t6_rst_addr", {16'd0, mem_addr}, 32'h0000);
    chk("t6_pre_nwr", wa.size(), 32'd2);
    if (wd.size() == 2) chk("t6_pre_d0", {16'd0, wd[0]}, 32'hA1A2);
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    clear_log();
    pulse_start();
    push_gap(8'h00); push_gap(8'h03);
    push_gap(8'hC0); push_gap(8'h01);
    push_gap(8'hC0); push_gap(8'h02);
    push_gap(8'hC0); push_gap(8'h03);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    chk("t6_nwr", wa.size(), 32'd3);
    if (wa.size() == 3) begin
      chk("t6_a0", {16'd0, wa[0]}, 32'h0000);
      chk("t6_d0", {16'd0, wd[0]}, 32'hC001);
      chk("t6_a1", {16'd0, wa[1]}, 32'h0002);
      chk("t6_d1", {16'd0, wd[1]}, 32'hC002);
      chk("t6_a2", {16'd0, wa[2]}, 32'h0004);
      chk("t6_d2", {16'd0, wd[2]}, 32'hC003);
    end
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t6_wl", {16'd0, words_loaded}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
